// File: rtl/pdl_buffer_pkg.sv
// Shared constants and address-select encodings for the PDL buffer.
package pdl_buffer_pkg;

    localparam int PDL_AW    = 10;
    localparam int PDL_DW    = 32;
    localparam int PDL_DEPTH = 1024;

    // Which source feeds a PDL address: the stack pointer or the index register.
    typedef enum logic {
        ASEL_PTR = 1'b0,
        ASEL_IDX = 1'b1
    } asel_e;

    // Where the pdl output register currently takes its value from.
    typedef enum logic [1:0] {
        PSEL_ZERO = 2'd0,
        PSEL_RAM  = 2'd1,
        PSEL_WB   = 2'd2
    } psel_e;

    // Read side: the index source wins over the pointer sources.
    function automatic asel_e rd_asel(input logic srcpdlidx);
        return srcpdlidx ? ASEL_IDX : ASEL_PTR;
    endfunction

    // Write side: the pointer destination wins over the index destination.
    function automatic asel_e wr_asel(input logic destpdltop);
        return destpdltop ? ASEL_PTR : ASEL_IDX;
    endfunction

endpackage

// File: rtl/pdl_ram.sv
// DEPTH x DW single-clock RAM, one synchronous read port, one write port, no reset.
module pdl_ram
    import pdl_buffer_pkg::*;
#(
    parameter int AW    = PDL_AW,
    parameter int DW    = PDL_DW,
    parameter int DEPTH = PDL_DEPTH
) (
    input  logic          i_clk,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata
);

    logic [DW-1:0] r_mem [DEPTH];
    logic [DW-1:0] r_rdata;

    // Write port plus registered read; a same-edge read sees the old contents.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/pdl_buffer.sv
// PDL buffer controller: read address mux, one-entry write-behind register
// with read bypass, M-bus drive enable and sticky pointer-wrap flags.
// DEPTH must equal 2**AW; pointer arithmetic upstream is modulo DEPTH.
module pdl_buffer
    import pdl_buffer_pkg::*;
#(
    parameter int AW    = PDL_AW,
    parameter int DW    = PDL_DW,
    parameter int DEPTH = PDL_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          state_read,
    input  logic          state_alu,
    input  logic          state_write,
    input  logic          state_fetch,
    input  logic [AW-1:0] pdlptr,
    input  logic [AW-1:0] pdlidx,
    input  logic          srcpdltop,
    input  logic          srcpdlpop,
    input  logic          srcpdlidx,
    input  logic          destpdltop,
    input  logic          destpdlx,
    input  logic [DW-1:0] l,
    input  logic          flag_clr,
    output logic [DW-1:0] pdl,
    output logic          pdldrive,
    output logic          wb_valid,
    output logic          pdl_oflow,
    output logic          pdl_uflow
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic          w_src_any;
    logic          w_rd_en;
    logic          w_wr_en;
    logic [AW-1:0] w_raddr;
    logic [AW-1:0] w_waddr;
    logic          w_hit;
    logic          w_commit;
    logic [DW-1:0] w_ram_rdata;
    logic          w_set_o;
    logic          w_set_u;

    logic          r_wb_valid;
    logic [AW-1:0] r_wb_addr;
    logic [DW-1:0] r_wb_data;
    logic [DW-1:0] r_byp_data;
    psel_e         r_psel;
    logic [AW-1:0] r_prev_ptr;
    logic          r_oflow;
    logic          r_uflow;

    assign w_src_any = srcpdltop | srcpdlpop | srcpdlidx;
    assign w_rd_en   = state_read & w_src_any;
    assign w_wr_en   = state_write & (destpdltop | destpdlx);
    assign w_raddr   = (rd_asel(srcpdlidx) == ASEL_IDX) ? pdlidx : pdlptr;
    assign w_waddr   = (wr_asel(destpdltop) == ASEL_PTR) ? pdlptr : pdlidx;
    assign w_hit     = r_wb_valid && (r_wb_addr == w_raddr);
    // The posted entry only reaches RAM when the next write displaces it.
    assign w_commit  = w_wr_en & r_wb_valid;
    assign w_set_o   = (r_prev_ptr == LAST_ADDR) && (pdlptr == '0);
    assign w_set_u   = (r_prev_ptr == '0) && (pdlptr == LAST_ADDR);

    pdl_ram #(
        .AW    (AW),
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .i_clk   (clk),
        .i_re    (w_rd_en),
        .i_raddr (w_raddr),
        .o_rdata (w_ram_rdata),
        .i_we    (w_commit),
        .i_waddr (r_wb_addr),
        .i_wdata (r_wb_data)
    );

    // Read strobe: remember whether this read is served by RAM or by the bypass.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_psel     <= PSEL_ZERO;
            r_byp_data <= '0;
        end else if (w_rd_en) begin
            r_psel     <= w_hit ? PSEL_WB : PSEL_RAM;
            r_byp_data <= r_wb_data;
        end
    end

    // Write strobe: post the new entry; the previous one is committed to RAM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_valid <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_data  <= '0;
        end else if (w_wr_en) begin
            r_wb_valid <= 1'b1;
            r_wb_addr  <= w_waddr;
            r_wb_data  <= l;
        end
    end

    // Sticky wrap flags; a wrap on the same edge as flag_clr keeps the flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev_ptr <= '0;
            r_oflow    <= 1'b0;
            r_uflow    <= 1'b0;
        end else begin
            r_prev_ptr <= pdlptr;
            r_oflow    <= w_set_o | (r_oflow & ~flag_clr);
            r_uflow    <= w_set_u | (r_uflow & ~flag_clr);
        end
    end

    // Output data select between reset value, RAM read port and bypass copy.
    always_comb begin
        pdl = '0;
        case (r_psel)
            PSEL_RAM: pdl = w_ram_rdata;
            PSEL_WB:  pdl = r_byp_data;
            default:  pdl = '0;
        endcase
    end

    assign pdldrive  = w_src_any & (state_alu | state_write | state_fetch);
    assign wb_valid  = r_wb_valid;
    assign pdl_oflow = r_oflow;
    assign pdl_uflow = r_uflow;

endmodule
